// File: rtl/iob_ram_rd_stream_pkg.sv
// iob_ram_rd_stream_pkg: state encodings and FIFO sizing shared by the memory-stream blocks
package iob_ram_rd_stream_pkg;
  localparam int FIFO_DEPTH = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/iob_fifo_2x.sv
// iob_fifo_2x: two-entry registered FIFO; head_o is always the oldest entry
module iob_fifo_2x #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] head_o,
  output logic [1:0]        count_o
);
  logic [DATA_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0] count_q, count_d;
  always_comb begin
    count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    head_d = push_i && (count_q == 2'd0 || (count_q == 2'd1 && pop_i)) ? din_i :
             pop_i && count_q == 2'd2 ? tail_q : head_q;
    tail_d = push_i && ((count_q == 2'd1 && !pop_i) || (count_q == 2'd2 && pop_i)) ? din_i : tail_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  assign head_o  = head_q;
  assign count_o = count_q;
endmodule

// File: rtl/iob_ram_rd_stream.sv
// iob_ram_rd_stream: streams a burst of RAM words out through a valid/ready port
import iob_ram_rd_stream_pkg::*;
module iob_ram_rd_stream #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0] len_q, len_d, rem_q, rem_d, cnt_q, cnt_d;
  logic inflight_q;
  logic [1:0] fifo_cnt;
  logic pop;
  assign m_valid  = fifo_cnt != 2'd0;
  assign pop      = m_valid && m_ready;
  assign m_last   = m_valid && (cnt_q + (ADDR_W+1)'(1) == len_q);
  assign busy     = state_q == RUN;
  assign done     = state_q == DONE;
  assign ram_addr = addr_q;
  // A slot freed by this cycle's pop may be reused by a read issued now
  assign ram_en = busy && rem_q != '0 &&
                  ({1'b0, fifo_cnt} + {2'b0, inflight_q} < 3'(FIFO_DEPTH) + {2'b0, pop});
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && start) begin
      state_d = length == '0 ? DONE : RUN;
      addr_d  = base_addr;
      len_d   = length;
      rem_d   = length;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      state_d = pop && m_last ? DONE : RUN;
      addr_d  = ram_en ? addr_q + ADDR_W'(1) : addr_q;
      rem_d   = ram_en ? rem_q - (ADDR_W+1)'(1) : rem_q;
      cnt_d   = pop ? cnt_q + (ADDR_W+1)'(1) : cnt_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      inflight_q <= ram_en;
    end
  end
  iob_fifo_2x #(.DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .din_i   (ram_dout),
    .head_o  (m_data),
    .count_o (fifo_cnt)
  );
endmodule

// File: tb/tb_iob_ram_rd_stream.sv
// tb_iob_ram_rd_stream: directed and random bursts checked against a queue-based reference
module tb_iob_ram_rd_stream;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0;
  logic rst, start, m_ready, ram_en, m_valid, m_last, busy, done;
  logic [AW-1:0] base_addr, ram_addr;
  logic [AW:0] length;
  logic [DW-1:0] ram_dout, m_data;
  logic [DW-1:0] mem [DEPTH];
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];
  iob_ram_rd_stream #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_ram_en"}, ram_en, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask
  // mode: 0 ready always high, 1 ready pattern 1,0,0, 2 random ready
  task automatic burst(input int base, input int len, input int mode, input int rst_after, input bit restart);
    int issued = 0;
    int acc = 0;
    int first_v = -1;
    bit prev_stall = 0;
    bit fin = 0;
    bit pop;
    logic [DW-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    logic [DW-1:0] exp_q[$];
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(base + i) % DEPTH]);
    @(negedge clk);
    start = 1'b1;
    base_addr = AW'(base);
    length = (AW+1)'(len);
    m_ready = 1'b1;
    #1 check("idle_busy", busy, 0);
    for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
      @(negedge clk);
      start = restart && cyc == 2;
      if (start) begin
        base_addr = AW'(base + 5);
        length = 3;
      end
      m_ready = mode == 0 ? 1'b1 : mode == 1 ? ((cyc - 1) % 3 == 0) : 1'($urandom_range(0, 1));
      #1;
      pop = m_valid && m_ready;
      check("done", done, acc == len);
      check("busy", busy, acc != len);
      if (acc == len) begin
        fin = 1;
        check("ram_en_done", ram_en, 0);
        check("m_valid_done", m_valid, 0);
      end else begin
        check("ram_en", ram_en, issued < len && (issued - acc - int'(pop)) < 2);
        if (ram_en) begin
          check("ram_addr", ram_addr, 64'((base + issued) % DEPTH));
          issued++;
        end
        if (m_valid) begin
          check("beat_in_range", acc < len, 1);
          if (acc < len) begin
            check("m_data", m_data, exp_q[acc]);
            check("m_last", m_last, acc == len - 1);
          end
          if (prev_stall) begin
            check("stable_data", m_data, prev_data);
            check("stable_last", m_last, prev_last);
          end
          if (first_v < 0) begin
            first_v = cyc;
            if (mode == 0) check("latency", cyc, 3);
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data = m_data;
        prev_last = m_last;
        if (pop) acc++;
        if (rst_after > 0 && acc == rst_after) begin
          @(posedge clk);
          #1 rst = 1'b1;
          #1 check_reset("rst_mid");
          @(negedge clk);
          @(negedge clk);
          rst = 1'b0;
          m_ready = 1'b1;
          for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            check("post_rst_valid", m_valid, 0);
            check("post_rst_en", ram_en, 0);
            check("post_rst_busy", busy, 0);
          end
          return;
        end
      end
    end
    if (!fin) check("timeout", 0, 1);
    check("issued_total", issued, len);
    @(negedge clk);
    start = 1'b0;
    #1 check("idle_after", busy | done, 0);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    m_ready = 1'b0;
    base_addr = '0;
    length = '0;
    ram_dout = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(32'h100 + i);
    repeat (2) @(negedge clk);
    #1 check_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    burst(0, 4, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    burst($urandom_range(0, DEPTH - 1), 8, 1, 0, 0);
    burst(14, 4, 0, 0, 0);
    burst(5, 0, 0, 0, 0);
    burst(0, 8, 0, 3, 0);
    burst(0, 2, 0, 0, 0);
    burst(2, 6, 0, 0, 1);
    burst(3, DEPTH, 2, 0, 0);
    for (int n = 0; n < 6; n++)
      burst($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH), $urandom_range(0, 2), 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
